// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution/pooling engine: FSM state encoding,
// default width constants and the unsigned clip (ReLU + saturate) helper.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_NUM_KERNELS = 2;
    localparam int DEF_PIX_W       = 8;
    localparam int DEF_W_W         = 8;
    localparam int DEF_SHIFT       = 4;
    localparam int DEF_CNT_W       = 16;

    // Clamp a signed value into 0 .. 2^w-1 (w up to 32).
    function automatic logic [31:0] clip_u(input logic signed [63:0] v,
                                           input int unsigned w);
        logic signed [63:0] lim;
        lim = (64'sd1 <<< w) - 64'sd1;
        if (v < 64'sd0) begin
            return '0;
        end else if (v > lim) begin
            return lim[31:0];
        end
        return v[31:0];
    endfunction

endpackage

// File: rtl/conv_mac.sv
// One 2x2 convolution kernel: registered products (stage 1) followed by the
// sum / arithmetic shift / clip datapath (stage 2, combinational here; the
// parent registers it or folds it into the pooling maximum).
module conv_mac
    import cnn_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int W_W   = DEF_W_W,
    parameter int SHIFT = DEF_SHIFT
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic [3:0][PIX_W-1:0] i_pix,
    input  logic [4*W_W-1:0]      i_w,
    output logic [PIX_W-1:0]      o_val
);

    localparam int PROD_W = PIX_W + W_W + 1;
    localparam int SUM_W  = PROD_W + 2;

    logic signed [PROD_W-1:0] r_prod_p1 [4];
    logic signed [SUM_W-1:0]  w_sum_p2;
    logic signed [SUM_W-1:0]  w_shr_p2;

    // Stage 1: pixel (zero-extended) times signed weight, held while stalled
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                r_prod_p1[i] <= PROD_W'(signed'({1'b0, i_pix[i]}))
                              * PROD_W'(signed'(i_w[i*W_W +: W_W]));
            end
        end
    end

    // Stage 2: accumulate the four products and scale down
    always_comb begin
        w_sum_p2 = '0;
        for (int i = 0; i < 4; i++) begin
            w_sum_p2 = w_sum_p2 + SUM_W'(r_prod_p1[i]);
        end
        w_shr_p2 = w_sum_p2 >>> SHIFT;
    end

    assign o_val = PIX_W'(clip_u(64'(w_shr_p2), PIX_W));

endmodule

// File: rtl/conv_pool_engine.sv
// Frame-based 2x2 convolution engine with NUM_KERNELS parallel kernels.
// Optional feature: define CONV_POOL_MAXPOOL_EN to emit the per-kernel max of
// each group of 4 consecutive windows (partial last group emitted at frame end).
module conv_pool_engine
    import cnn_pkg::*;
#(
    parameter int NUM_KERNELS = DEF_NUM_KERNELS,
    parameter int PIX_W       = DEF_PIX_W,
    parameter int W_W         = DEF_W_W,
    parameter int SHIFT       = DEF_SHIFT,
    parameter int CNT_W       = DEF_CNT_W,
    localparam int IDX_W      = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              kr_we,
    input  logic [IDX_W-1:0]                  kr_idx,
    input  logic [4*W_W-1:0]                  kr_data,
    input  logic                              start,
    input  logic [CNT_W-1:0]                  num_windows,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [3:0][PIX_W-1:0]             pixels,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_KERNELS-1:0][PIX_W-1:0] result,
    output logic                              busy,
    output logic                              done
);

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [CNT_W-1:0]                    r_num;
    logic [CNT_W-1:0]                    r_cnt;
    logic [CNT_W-1:0]                    w_cnt_nxt;
    logic                                r_zero_done;
    logic [4*W_W-1:0]                    r_kern [NUM_KERNELS];
    logic                                r_vld_p1;
    logic                                r_vld_p2;
    logic [NUM_KERNELS-1:0][PIX_W-1:0]   w_clip;
    logic [NUM_KERNELS-1:0][PIX_W-1:0]   r_res_p2;
    logic                                w_adv;
    logic                                w_acc;
    logic                                w_last;
    logic                                w_fin;

    // The whole pipeline moves together, so a stall can neither drop nor repeat a window.
    assign w_adv     = !r_vld_p2 || out_ready;
    assign in_ready  = (r_state == ST_RUN) && w_adv;
    assign w_acc     = in_valid && in_ready;
    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign w_last    = (w_cnt_nxt == r_num);
    // No window is left in stage 1 during DRAIN once the output register holds the final result.
    assign w_fin     = (r_state == ST_DRAIN) && r_vld_p2 && out_ready && !r_vld_p1;

    assign out_valid = r_vld_p2;
    assign result    = r_res_p2;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_zero_done || w_fin;

    // Next-state decode for the frame controller
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start && (num_windows != '0)) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_acc && w_last)              w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_fin)                        w_state_nxt = ST_IDLE;
            default:                                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Frame state, window count and the empty-frame done pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_num       <= '0;
            r_cnt       <= '0;
            r_zero_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_zero_done <= (r_state == ST_IDLE) && start && (num_windows == '0);
            if ((r_state == ST_IDLE) && start) begin
                r_num <= num_windows;
                r_cnt <= '0;
            end else if (w_acc) begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

    // Kernel weight registers, writable only between frames
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < NUM_KERNELS; k++) r_kern[k] <= '0;
        end else if (kr_we && (r_state == ST_IDLE)) begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                if (kr_idx == IDX_W'(k)) r_kern[k] <= kr_data;
            end
        end
    end

    // Stage 1 boundary: one MAC per kernel
    for (genvar g = 0; g < NUM_KERNELS; g++) begin : g_mac
        conv_mac #(
            .PIX_W (PIX_W),
            .W_W   (W_W),
            .SHIFT (SHIFT)
        ) u_mac (
            .clk   (clk),
            .i_en  (w_adv),
            .i_pix (pixels),
            .i_w   (r_kern[g]),
            .o_val (w_clip[g])
        );
    end

`ifdef CONV_POOL_MAXPOOL_EN
    logic                              r_last_p1;
    logic [1:0]                        r_pool_cnt;
    logic [NUM_KERNELS-1:0][PIX_W-1:0] r_pool_max;
    logic [NUM_KERNELS-1:0][PIX_W-1:0] w_pool_m;
    logic                              w_emit;

    // Stage 1 valid plus the frame-end marker that flushes a partial group
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1  <= w_acc;
            r_last_p1 <= w_acc && w_last;
        end
    end

    // Running maximum including the window now leaving stage 1
    always_comb begin
        w_pool_m = '0;
        for (int k = 0; k < NUM_KERNELS; k++) begin
            w_pool_m[k] = ((r_pool_cnt == 2'd0) || (w_clip[k] > r_pool_max[k]))
                        ? w_clip[k] : r_pool_max[k];
        end
        w_emit = r_vld_p1 && ((r_pool_cnt == 2'd3) || r_last_p1);
    end

    // Stage 2 boundary: pool accumulators and output register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_p2   <= 1'b0;
            r_res_p2   <= '0;
            r_pool_cnt <= '0;
            r_pool_max <= '0;
        end else if (w_adv) begin
            r_vld_p2 <= w_emit;
            if (w_emit) r_res_p2 <= w_pool_m;
            if (r_vld_p1) begin
                if (w_emit) begin
                    r_pool_cnt <= '0;
                end else begin
                    r_pool_cnt <= r_pool_cnt + 2'd1;
                    r_pool_max <= w_pool_m;
                end
            end
        end
    end
`else
    // Stage 1 valid
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1 <= w_acc;
        end
    end

    // Stage 2 boundary: output register, one result per window
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld_p2 <= 1'b0;
            r_res_p2 <= '0;
        end else if (w_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) r_res_p2 <= w_clip;
        end
    end
`endif

endmodule
